// File: rtl/ir_packet_scheduler.sv
// IR packet scheduler: register window, launch request tracking and a
// launch FSM that throttles SEND_PACKET against the transmitter busy flag.
module ir_packet_scheduler #(
    parameter logic [7:0]  BaseAddr    = 8'hA0,
    parameter int unsigned TickDiv     = 100000,
    parameter int unsigned BusyTimeout = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic       TX_BUSY,
    output logic       SEND_PACKET,
    output logic [3:0] COMMAND,
    output logic [1:0] CAR_SELECT
);

    localparam int unsigned PreW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(TickDiv - 1);
    localparam int unsigned ToW = (BusyTimeout > 1) ? $clog2(BusyTimeout) : 1;
    localparam logic [ToW-1:0] ToMax = ToW'(BusyTimeout - 1);

    typedef enum logic [1:0] {StIdle, StStrobe, StWaitBusy, StWaitDone} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cmd_q;
    logic [1:0]      car_q;
    logic            enable_q;
    logic [7:0]      period_q;
    logic            pending_q, pending_d;
    logic [PreW-1:0] pre_q;
    logic [7:0]      per_cnt_q, per_cnt_d;
    logic [ToW-1:0]  to_q, to_d;
    logic [3:0]      command_q;
    logic [1:0]      car_sel_q;
    logic            rd_en_q, rd_en_d;
    logic [7:0]      rd_data_q, rd_data_d;

    logic [7:0] offset;
    logic       in_win;
    logic       wr_cmd, wr_car, wr_ctrl, wr_period;
    logic       ms_tick, per_hit, launch;
    logic [7:0] per_eff;

    // Offset relative to the base so a non-aligned base still decodes correctly.
    assign offset    = BUS_ADDR - BaseAddr;
    assign in_win    = (offset[7:2] == 6'd0);
    assign wr_cmd    = BUS_WE && in_win && (offset[1:0] == 2'd0);
    assign wr_car    = BUS_WE && in_win && (offset[1:0] == 2'd1);
    assign wr_ctrl   = BUS_WE && in_win && (offset[1:0] == 2'd2);
    assign wr_period = BUS_WE && in_win && (offset[1:0] == 2'd3);

    assign ms_tick = (pre_q == PreMax);
    assign per_eff = (period_q == 8'd0) ? 8'd1 : period_q;
    assign launch  = (state_q == StIdle) && pending_q && !TX_BUSY;

    assign SEND_PACKET = (state_q == StStrobe);
    assign COMMAND     = command_q;
    assign CAR_SELECT  = car_sel_q;
    assign BUS_DATA    = rd_en_q ? rd_data_q : 8'hzz;

    // Free-running millisecond prescaler.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pre_q <= '0;
        end else begin
            pre_q <= ms_tick ? '0 : pre_q + PreW'(1);
        end
    end

    // Bus-writable configuration registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cmd_q    <= 4'd0;
            car_q    <= 2'd0;
            enable_q <= 1'b0;
            period_q <= 8'd100;
        end else begin
            if (wr_cmd)    cmd_q    <= BUS_DATA[3:0];
            if (wr_car)    car_q    <= BUS_DATA[1:0];
            if (wr_ctrl)   enable_q <= BUS_DATA[0];
            if (wr_period) period_q <= BUS_DATA;
        end
    end

    // Period counter next state; a hit raises a launch request.
    always_comb begin
        per_cnt_d = per_cnt_q;
        per_hit   = 1'b0;
        if (!enable_q || wr_period) begin
            per_cnt_d = 8'd0;
        end else if (ms_tick) begin
            if (per_cnt_q + 8'd1 == per_eff) begin
                per_hit   = 1'b1;
                per_cnt_d = 8'd0;
            end else begin
                per_cnt_d = per_cnt_q + 8'd1;
            end
        end
    end

    // Single pending flag; a new request wins over the launch clear.
    always_comb begin
        pending_d = pending_q;
        if (wr_cmd || (wr_ctrl && BUS_DATA[1]) || per_hit) begin
            pending_d = 1'b1;
        end else if (launch) begin
            pending_d = 1'b0;
        end
    end

    // Launch FSM next state and busy-timeout counter.
    always_comb begin
        state_d = state_q;
        to_d    = to_q;
        unique case (state_q)
            StIdle: begin
                if (launch) state_d = StStrobe;
            end
            StStrobe: begin
                state_d = StWaitBusy;
                to_d    = '0;
            end
            StWaitBusy: begin
                if (TX_BUSY) begin
                    state_d = StWaitDone;
                end else if (to_q == ToMax) begin
                    // Transmitter never answered: drop the packet, no retry.
                    state_d = StIdle;
                end else begin
                    to_d = to_q + ToW'(1);
                end
            end
            StWaitDone: begin
                if (!TX_BUSY) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Read mux; data and drive enable are registered one cycle behind the address.
    always_comb begin
        rd_en_d   = !BUS_WE && in_win;
        rd_data_d = 8'd0;
        unique case (offset[1:0])
            2'd0: rd_data_d = {4'd0, cmd_q};
            2'd1: rd_data_d = {6'd0, car_q};
            2'd2: rd_data_d = {pending_q, 6'd0, enable_q};
            2'd3: rd_data_d = period_q;
            default: rd_data_d = 8'd0;
        endcase
    end

    // State, counters, frozen packet fields and read pipeline.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            per_cnt_q <= 8'd0;
            to_q      <= '0;
            command_q <= 4'd0;
            car_sel_q <= 2'd0;
            rd_en_q   <= 1'b0;
            rd_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            per_cnt_q <= per_cnt_d;
            to_q      <= to_d;
            rd_en_q   <= rd_en_d;
            rd_data_q <= rd_data_d;
            // Snapshot uses the register values from before any same-edge write.
            if (launch) begin
                command_q <= cmd_q;
                car_sel_q <= car_q;
            end
        end
    end

endmodule

// File: tb/tb_ir_packet_scheduler.sv
// Scoreboard bench for ir_packet_scheduler: stimulus pushes expected packets
// and read data; a negedge monitor pops and compares whenever the DUT presents them.
module tb_ir_packet_scheduler;

    localparam int unsigned TickDiv     = 10;
    localparam int unsigned BusyTimeout = 16;
    localparam logic [7:0]  A0 = 8'hA0;
    localparam logic [7:0]  A1 = 8'hA1;
    localparam logic [7:0]  A2 = 8'hA2;
    localparam logic [7:0]  A3 = 8'hA3;
    localparam logic [7:0]  AOff = 8'h90;

    typedef struct packed {
        logic [3:0] cmd;
        logic [1:0] car;
    } pkt_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    wire  [7:0] BUS_DATA;
    logic [7:0] BUS_ADDR = 8'h90;
    logic       BUS_WE = 1'b0;
    wire        TX_BUSY;
    logic       SEND_PACKET;
    logic [3:0] COMMAND;
    logic [1:0] CAR_SELECT;

    logic       drv_en = 1'b0;
    logic [7:0] drv_data = 8'd0;
    logic       busy_m = 1'b0;
    logic       busy_a = 1'b0;
    logic       busy_auto = 1'b0;
    int         busy_len = 5;

    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          launch_cnt = 0;
    int unsigned launch_t[$];
    pkt_t        exp_pkt[$];
    logic [7:0]  exp_rd[$];

    // Reference register contents as the bus has written them.
    logic [3:0] m_cmd = 4'd0;
    logic [1:0] m_car = 2'd0;
    logic       m_enable = 1'b0;
    logic [7:0] m_period = 8'd100;

    assign BUS_DATA = drv_en ? drv_data : 8'hzz;
    assign TX_BUSY  = busy_m | busy_a;

    ir_packet_scheduler #(
        .BaseAddr(8'hA0),
        .TickDiv(TickDiv),
        .BusyTimeout(BusyTimeout)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .BUS_DATA(BUS_DATA),
        .BUS_ADDR(BUS_ADDR),
        .BUS_WE(BUS_WE),
        .TX_BUSY(TX_BUSY),
        .SEND_PACKET(SEND_PACKET),
        .COMMAND(COMMAND),
        .CAR_SELECT(CAR_SELECT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Bus write; called and returns 1 time unit after a rising edge.
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        BUS_ADDR = a;
        BUS_WE   = 1'b1;
        drv_data = d;
        drv_en   = 1'b1;
        @(posedge CLK);
        #1;
        BUS_WE   = 1'b0;
        drv_en   = 1'b0;
        BUS_ADDR = AOff;
        case (a)
            A0: m_cmd = d[3:0];
            A1: m_car = d[1:0];
            A2: m_enable = d[0];
            A3: m_period = d;
            default: ;
        endcase
    endtask

    // Bus read; expected byte goes to the scoreboard, then an idle turnaround cycle.
    task automatic rd(input logic [7:0] a, input logic [7:0] e);
        exp_rd.push_back(e);
        BUS_ADDR = a;
        BUS_WE   = 1'b0;
        @(posedge CLK);
        #1;
        BUS_ADDR = AOff;
        @(posedge CLK);
        #1;
    endtask

    task automatic push_pkt(input logic [3:0] c, input logic [1:0] r);
        pkt_t p;
        p.cmd = c;
        p.car = r;
        exp_pkt.push_back(p);
    endtask

    task automatic wait_launches(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (launch_cnt < target && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checks++;
        if (launch_cnt < target) begin
            errors++;
            $display("FAIL %s: launches=%0d, expected %0d within %0d cycles",
                     name, launch_cnt, target, budget);
        end
    endtask

    // Monitor: compares every launch and every driven read cycle against the scoreboard.
    initial begin
        pkt_t       e;
        logic [7:0] r;
        forever begin
            @(negedge CLK);
            if (!RESET && SEND_PACKET === 1'b1) begin
                launch_cnt++;
                launch_t.push_back(cyc);
                checks++;
                if (exp_pkt.size() == 0) begin
                    errors++;
                    $display("FAIL launch: unexpected SEND_PACKET at cycle %0d (COMMAND=%0h CAR_SELECT=%0d)",
                             cyc, COMMAND, CAR_SELECT);
                end else begin
                    e = exp_pkt.pop_front();
                    if (COMMAND !== e.cmd || CAR_SELECT !== e.car) begin
                        errors++;
                        $display("FAIL launch: got COMMAND=%0h CAR_SELECT=%0d, expected %0h/%0d",
                                 COMMAND, CAR_SELECT, e.cmd, e.car);
                    end
                end
            end
            if (!drv_en && BUS_DATA !== 8'hzz) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL read: unexpected bus drive %0h at cycle %0d", BUS_DATA, cyc);
                end else begin
                    r = exp_rd.pop_front();
                    if (BUS_DATA !== r) begin
                        errors++;
                        $display("FAIL read: got %0h, expected %0h", BUS_DATA, r);
                    end
                end
            end
        end
    end

    // Transmitter model: answers a launch with busy_len cycles of TX_BUSY.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (busy_auto && SEND_PACKET === 1'b1) begin
                busy_a = 1'b1;
                repeat (busy_len) @(posedge CLK);
                #1;
                busy_a = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int unsigned t_w, t1, t2;
        int          base;
        logic [3:0]  c;
        logic [1:0]  r;

        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        wait_cyc(2);

        // Reset values and bus release.
        rd(A0, 8'h00);
        rd(A1, 8'h00);
        rd(A2, 8'h00);
        rd(A3, 8'h64);
        wait_cyc(1);
        check("bus_release", {31'd0, BUS_DATA === 8'hzz}, 32'd1);
        check("reset_command", {28'd0, COMMAND}, 32'd0);

        // Single command launch and latency.
        n0 = launch_cnt;
        wr(A1, 8'd2);
        push_pkt(4'h5, 2'd2);
        wr(A0, 8'h05);
        t_w = cyc;
        wait_launches(n0 + 1, 10, "single_launch");
        check("single_latency", launch_t[launch_t.size()-1] - t_w, 32'd1);
        busy_m = 1'b1;
        wait_cyc(500);
        busy_m = 1'b0;
        wait_cyc(20);
        check("single_count", launch_cnt - n0, 32'd1);
        check("single_command", {28'd0, COMMAND}, 32'h5);

        // Coalescing while busy; last CMD wins, COMMAND frozen meanwhile.
        busy_m = 1'b1;
        wait_cyc(2);
        n0 = launch_cnt;
        wr(A0, 8'h03);
        wr(A0, 8'h09);
        wr(A0, 8'h0C);
        check("busy_command_frozen", {28'd0, COMMAND}, 32'h5);
        rd(A2, 8'h80);
        push_pkt(4'hC, 2'd2);
        busy_m = 1'b0;
        wait_launches(n0 + 1, 10, "coalesce_launch");
        wait_cyc(40);
        check("coalesce_count", launch_cnt - n0, 32'd1);

        // Busy never rises: timeout, then a FORCE launches again.
        n0 = launch_cnt;
        push_pkt(m_cmd, m_car);
        wr(A2, 8'h02);
        wait_launches(n0 + 1, 10, "force_launch");
        t1 = launch_t[launch_t.size()-1];
        push_pkt(m_cmd, m_car);
        wr(A2, 8'h02);
        wait_launches(n0 + 2, 40, "timeout_relaunch");
        t2 = launch_t[launch_t.size()-1];
        check_range("timeout_gap", int'(t2 - t1), BusyTimeout + 1, BusyTimeout + 3);
        wait_cyc(30);
        check("timeout_count", launch_cnt - n0, 32'd2);

        // Periodic launches: PERIOD=3 ms at TickDiv=10 cycles.
        busy_len  = 5;
        busy_auto = 1'b1;
        wr(A3, 8'd3);
        n0 = launch_cnt;
        for (int i = 0; i < 4; i++) push_pkt(m_cmd, m_car);
        wr(A2, 8'h01);
        t_w = cyc;
        wait_launches(n0 + 4, 200, "periodic_launch");
        base = launch_t.size() - 4;
        check_range("periodic_first", int'(launch_t[base] - t_w), TickDiv * 2, TickDiv * 4 + 2);
        for (int i = 1; i < 4; i++) begin
            check("periodic_interval", launch_t[base+i] - launch_t[base+i-1], 3 * TickDiv);
        end
        wr(A2, 8'h00);
        wait_cyc(100);
        check("periodic_stop", launch_cnt - n0, 32'd4);

        // PERIOD=0 behaves as 1 ms.
        wr(A3, 8'd0);
        n0 = launch_cnt;
        for (int i = 0; i < 3; i++) push_pkt(m_cmd, m_car);
        wr(A2, 8'h01);
        wait_launches(n0 + 3, 100, "period0_launch");
        base = launch_t.size() - 3;
        for (int i = 1; i < 3; i++) begin
            check("period0_interval", launch_t[base+i] - launch_t[base+i-1], TickDiv);
        end
        wr(A2, 8'h00);
        wait_cyc(50);
        check("period0_stop", launch_cnt - n0, 32'd3);
        wr(A3, 8'd100);
        rd(A3, m_period);

        // Randomised command/car traffic with a random-length transmitter.
        for (int k = 0; k < 8; k++) begin
            c        = 4'($urandom_range(15, 0));
            r        = 2'($urandom_range(3, 0));
            busy_len = int'($urandom_range(20, 1));
            n0       = launch_cnt;
            wr(A1, {6'd0, r});
            rd(A1, {6'd0, m_car});
            push_pkt(c, r);
            wr(A0, {4'd0, c});
            wait_launches(n0 + 1, 10, "random_launch");
            wait_cyc(40);
            rd(A0, {4'd0, m_cmd});
            rd(A2, {7'd0, m_enable});
        end
        busy_auto = 1'b0;

        // Asynchronous reset in WAIT_DONE with a request pending.
        n0 = launch_cnt;
        wr(A1, 8'd1);
        push_pkt(4'hA, 2'd1);
        wr(A0, 8'h0A);
        wait_launches(n0 + 1, 10, "prereset_launch");
        busy_m = 1'b1;
        wait_cyc(4);
        wr(A2, 8'h02);
        check("prereset_command", {28'd0, COMMAND}, 32'hA);
        #2;
        RESET = 1'b1;
        #1;
        check("reset_send", {31'd0, SEND_PACKET}, 32'd0);
        check("reset_command_async", {28'd0, COMMAND}, 32'd0);
        check("reset_car_async", {30'd0, CAR_SELECT}, 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET    = 1'b0;
        busy_m   = 1'b0;
        m_cmd    = 4'd0;
        m_car    = 2'd0;
        m_enable = 1'b0;
        m_period = 8'd100;
        rd(A0, 8'h00);
        rd(A1, 8'h00);
        rd(A2, 8'h00);
        rd(A3, 8'h64);
        n0 = launch_cnt;
        wait_cyc(60);
        check("postreset_idle", launch_cnt - n0, 32'd0);
        push_pkt(4'h0, 2'd0);
        wr(A2, 8'h02);
        wait_launches(n0 + 1, 10, "postreset_launch");
        wait_cyc(30);

        check("pkt_queue_empty", exp_pkt.size(), 32'd0);
        check("read_queue_empty", exp_rd.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
